snax_data_reshuffler_tiled: RTL and testbench
=============================================

SNAX_DATA_RESHUFFLER_TILED -- requirements
Module: snax_data_reshuffler_tiled

Interface
REQ-001 Parameter DataWidth, default 512: stream beat width in bits.
REQ-002 Parameter ElemWidth, default 8: element width in bits.
REQ-003 Parameter RegRWCount, default 2: number of CSR RW registers.
REQ-004 Parameter RegROCount, default 3: number of CSR RO registers.
REQ-005 Parameter RegDataWidth, default 32: CSR register width.
REQ-006 Derived: E = DataWidth/ElemWidth elements per beat; N = sqrt(E) tile side; E SHALL be a perfect square, else elaboration fails (512/8 gives N=8).
REQ-007 clk_i  input  1  single clock, all state on rising edge.
REQ-008 rst_ni  input  1  reset, asynchronous, active-low.
REQ-009 stream2acc_0_data_i  input  DataWidth  input beat, element e at bits [e*ElemWidth +: ElemWidth].
REQ-010 stream2acc_0_valid_i  input  1  input beat valid.
REQ-011 stream2acc_0_ready_o  output  1  input beat ready.
REQ-012 acc2stream_0_data_o  output  DataWidth  output beat.
REQ-013 acc2stream_0_valid_o  output  1  output beat valid.
REQ-014 acc2stream_0_ready_i  input  1  output beat ready.
REQ-015 csr_reg_set_i  input  RegRWCount x RegDataWidth  [0][1:0] mode, [1] beat count.
REQ-016 csr_reg_set_valid_i  input  1  CSR launch valid.
REQ-017 csr_reg_set_ready_o  output  1  CSR launch ready.
REQ-018 csr_reg_ro_set_o  output  RegROCount x RegDataWidth  [0] busy in bit 0, upper bits 0; [1] cycle counter; [2] output beats completed.

Function
REQ-019 FSM states IDLE and RUN; csr_reg_set_ready_o = 1 exactly in IDLE.
REQ-020 CSR handshake (valid & ready) latches mode and beat count, clears both RO counters; count 0 -> stay IDLE (no-op), else -> RUN next cycle.
REQ-021 Mode 0 pass-through: out element e = in element e.
REQ-022 Mode 1 tile transpose: out element c*N+r = in element r*N+c, r,c in 0..N-1.
REQ-023 Mode 2 element reverse: out element e = in element E-1-e.
REQ-024 Mode 3 SHALL behave as mode 0.
REQ-025 Single output register stage: input accepted in cycle t appears on acc2stream_0_data_o with valid in cycle t+1.
REQ-026 stream2acc_0_ready_o = RUN & (inputs remaining > 0) & (!acc2stream_0_valid_o | acc2stream_0_ready_i); full throughput one beat/cycle under no backpressure.
REQ-027 While acc2stream_0_valid_o & !acc2stream_0_ready_i, output data and valid SHALL hold stable.
REQ-028 Simultaneous output handshake and input accept in one cycle: register reloads, valid stays 1.
REQ-029 Input-remaining counter decrements per input handshake; no input accepted once it reaches 0.
REQ-030 csr_reg_ro_set_o[2] increments per output handshake; when it equals beat count, FSM returns to IDLE next cycle and valid drops.
REQ-031 csr_reg_ro_set_o[1] increments every RUN cycle, saturates at 2^RegDataWidth-1, holds in IDLE until next launch.
REQ-032 Busy (csr_reg_ro_set_o[0][0]) = (state == RUN).
REQ-033 CSR valid during RUN is ignored (not latched) and held off by ready = 0.

Reset
REQ-034 On rst_ni low, asynchronously: state IDLE, acc2stream_0_valid_o 0, data register 0, all counters 0, stream2acc_0_ready_o 0, csr_reg_set_ready_o 1 once reset released.
REQ-035 Reset mid-RUN aborts the job; in-flight beat discarded; no output after release until a new launch.

Verification
REQ-036 Mode 0, count 4, beats 0x01..0x04 replicated, ready_i=1 -> 4 identical outputs, each 1 cycle after input; RO[2]=4; RO[1]=5; busy falls.
REQ-037 Mode 1, count 1, input element e = e (bytes 0..63) -> output byte c*8+r = r*8+c (e.g. out byte 1 = 8, out byte 63 = 63).
REQ-038 Mode 2, count 1, input byte e = e -> output byte e = 63-e.
REQ-039 Mode 0, count 3, acc2stream_0_ready_i low 5 cycles mid-stream -> output held stable, stream2acc_0_ready_o low, no beat lost or duplicated, RO[2]=3.
REQ-040 Launch with count 0 -> busy never set, csr_reg_set_ready_o stays 1, no output; CSR valid during RUN -> ignored, mode unchanged.
REQ-041 Assert rst_ni low after 2 of 6 beats -> valid 0 immediately, busy 0, RO counters 0; new launch count 2 completes normally.

Source files
------------

// File: rtl/snax_data_reshuffler_tiled.sv
// ---------------------------------------------------------------------------
// snax_data_reshuffler_tiled
//
// Streaming element reshuffler. A CSR launch latches a mode and a beat count;
// the block then takes that many input beats, rearranges the elements of each
// beat and emits every result through a single output register stage.
//   mode 0 / 3 : pass-through
//   mode 1     : N x N tile transpose (out elem c*N+r = in elem r*N+c)
//   mode 2     : element reverse     (out elem e = in elem E-1-e)
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   stream2acc_0_*          input beat stream (valid/ready)
//   acc2stream_0_*          output beat stream (valid/ready)
//   csr_reg_set_i           [0][1:0] mode, [1] beat count
//   csr_reg_set_valid_i/    launch handshake, ready only while idle
//   csr_reg_set_ready_o
//   csr_reg_ro_set_o        [0] busy (bit 0), [1] run cycle counter,
//                           [2] output beats completed
// ---------------------------------------------------------------------------
module snax_data_reshuffler_tiled #(
   parameter int DataWidth    = 512,
   parameter int ElemWidth    = 8,
   parameter int RegRWCount   = 2,
   parameter int RegROCount   = 3,
   parameter int RegDataWidth = 32
) (
   input  logic                                     clk_i,
   input  logic                                     rst_ni,
   input  logic [DataWidth-1:0]                     stream2acc_0_data_i,
   input  logic                                     stream2acc_0_valid_i,
   output logic                                     stream2acc_0_ready_o,
   output logic [DataWidth-1:0]                     acc2stream_0_data_o,
   output logic                                     acc2stream_0_valid_o,
   input  logic                                     acc2stream_0_ready_i,
   input  logic [RegRWCount-1:0][RegDataWidth-1:0]  csr_reg_set_i,
   input  logic                                     csr_reg_set_valid_i,
   output logic                                     csr_reg_set_ready_o,
   output logic [RegROCount-1:0][RegDataWidth-1:0]  csr_reg_ro_set_o
);

   localparam int E = DataWidth / ElemWidth;

   // Integer square root evaluated at elaboration time.
   function automatic int isqrt(input int v);
      int r;
      r = 0;
      for (int i = 0; i <= v; i++) begin
         if (i * i <= v) begin
            r = i;
         end
      end
      return r;
   endfunction

   localparam int N = isqrt(E);

   generate
      if (N * N != E) begin : g_not_square
         $error("snax_data_reshuffler_tiled: elements per beat must be a perfect square");
      end
   endgenerate

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e                  state_r;
   state_e                  next_state_s;
   logic [1:0]              mode_r;
   logic [RegDataWidth-1:0] count_r;
   logic [RegDataWidth-1:0] remain_r;
   logic [RegDataWidth-1:0] done_r;
   logic [RegDataWidth-1:0] cycles_r;
   logic [DataWidth-1:0]    data_r;
   logic                    valid_r;
   logic [DataWidth-1:0]    shuf_s;
   logic                    launch_s;
   logic                    in_ready_s;
   logic                    in_hs_s;
   logic                    out_hs_s;
   logic                    last_out_s;
   logic                    csr_unused_s;

   // Only the mode bits and the count word are consumed from the CSR bus.
   assign csr_unused_s = ^csr_reg_set_i;

   assign csr_reg_set_ready_o  = (state_r == ST_IDLE);
   assign launch_s             = csr_reg_set_valid_i & csr_reg_set_ready_o;
   // Accept a new beat only if the output slot is free or drains this cycle.
   assign in_ready_s           = (state_r == ST_RUN) & (remain_r != {RegDataWidth{1'b0}})
                                 & (~valid_r | acc2stream_0_ready_i);
   assign in_hs_s              = stream2acc_0_valid_i & in_ready_s;
   assign out_hs_s             = valid_r & acc2stream_0_ready_i;
   // The handshake that completes the job ends RUN on the same edge.
   assign last_out_s           = out_hs_s & ((done_r + RegDataWidth'(1)) == count_r);
   assign stream2acc_0_ready_o = in_ready_s;
   assign acc2stream_0_data_o  = data_r;
   assign acc2stream_0_valid_o = valid_r;

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic: a zero-count launch is a no-op and stays idle.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (launch_s && (csr_reg_set_i[1] != {RegDataWidth{1'b0}})) begin
               next_state_s = ST_RUN;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (last_out_s) begin
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_RUN;
            end
         end
         default: next_state_s = ST_IDLE;
      endcase
   end

   // Job configuration and progress counters.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mode_r   <= 2'd0;
         count_r  <= {RegDataWidth{1'b0}};
         remain_r <= {RegDataWidth{1'b0}};
         done_r   <= {RegDataWidth{1'b0}};
         cycles_r <= {RegDataWidth{1'b0}};
      end else if (launch_s) begin
         mode_r   <= csr_reg_set_i[0][1:0];
         count_r  <= csr_reg_set_i[1];
         remain_r <= csr_reg_set_i[1];
         done_r   <= {RegDataWidth{1'b0}};
         cycles_r <= {RegDataWidth{1'b0}};
      end else if (state_r == ST_RUN) begin
         if (in_hs_s) begin
            remain_r <= remain_r - RegDataWidth'(1);
         end
         if (out_hs_s) begin
            done_r <= done_r + RegDataWidth'(1);
         end
         if (cycles_r != {RegDataWidth{1'b1}}) begin
            cycles_r <= cycles_r + RegDataWidth'(1);
         end
      end
   end

   // Element permutation selected by the latched mode.
   always_comb begin
      shuf_s = stream2acc_0_data_i;
      case (mode_r)
         2'd1: begin
            for (int r = 0; r < N; r++) begin
               for (int c = 0; c < N; c++) begin
                  shuf_s[(c*N+r)*ElemWidth +: ElemWidth] =
                     stream2acc_0_data_i[(r*N+c)*ElemWidth +: ElemWidth];
               end
            end
         end
         2'd2: begin
            for (int e = 0; e < E; e++) begin
               shuf_s[e*ElemWidth +: ElemWidth] =
                  stream2acc_0_data_i[(E-1-e)*ElemWidth +: ElemWidth];
            end
         end
         default: shuf_s = stream2acc_0_data_i;
      endcase
   end

   // Output register stage: load on accept, clear when drained without refill.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_r  <= {DataWidth{1'b0}};
         valid_r <= 1'b0;
      end else if (in_hs_s) begin
         data_r  <= shuf_s;
         valid_r <= 1'b1;
      end else if (out_hs_s) begin
         valid_r <= 1'b0;
      end
   end

   // Read-only status words.
   always_comb begin
      csr_reg_ro_set_o    = {(RegROCount*RegDataWidth){1'b0}};
      csr_reg_ro_set_o[0] = {{(RegDataWidth-1){1'b0}}, (state_r == ST_RUN)};
      csr_reg_ro_set_o[1] = cycles_r;
      csr_reg_ro_set_o[2] = done_r;
   end

endmodule

// File: tb/tb_snax_data_reshuffler_tiled.sv
module tb_snax_data_reshuffler_tiled;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [511:0]      in_data;
   logic              in_valid;
   logic              in_ready;
   logic [511:0]      out_data;
   logic              out_valid;
   logic              acc_ready;
   logic [1:0][31:0]  csr_set;
   logic              csr_valid;
   logic              csr_ready;
   logic [2:0][31:0]  ro;

   int           errors = 0;
   int           checks = 0;
   logic [511:0] beats [0:15];
   logic [511:0] exp_q [$];
   logic [511:0] last_out;

   always #5 clk = ~clk;

   snax_data_reshuffler_tiled dut (
      .clk_i                (clk),
      .rst_ni               (rst_n),
      .stream2acc_0_data_i  (in_data),
      .stream2acc_0_valid_i (in_valid),
      .stream2acc_0_ready_o (in_ready),
      .acc2stream_0_data_o  (out_data),
      .acc2stream_0_valid_o (out_valid),
      .acc2stream_0_ready_i (acc_ready),
      .csr_reg_set_i        (csr_set),
      .csr_reg_set_valid_i  (csr_valid),
      .csr_reg_set_ready_o  (csr_ready),
      .csr_reg_ro_set_o     (ro)
   );

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference: for each output element, compute which input element feeds it.
   function automatic logic [511:0] model(input logic [1:0] m, input logic [511:0] x);
      logic [511:0] y;
      int src;
      for (int o = 0; o < 64; o++) begin
         if (m == 2'd1)      src = (o % 8) * 8 + (o / 8);
         else if (m == 2'd2) src = 63 - o;
         else                src = o;
         y[o*8 +: 8] = x[src*8 +: 8];
      end
      return y;
   endfunction

   task automatic fill_random(input int cnt);
      for (int i = 0; i < cnt; i++)
         for (int w = 0; w < 16; w++)
            beats[i][w*32 +: 32] = $urandom;
   endtask

   task automatic launch(input logic [1:0] m, input int cnt);
      csr_set[0] = {30'd0, m};
      csr_set[1] = cnt;
      csr_valid  = 1'b1;
      in_valid   = 1'b0;
      #1;
      chk("csr_ready_idle", csr_ready, 1'b1);
      @(negedge clk);
      csr_valid = 1'b0;
   endtask

   // Runs one job; returns at a falling edge. abort_after stops early after that many outputs.
   task automatic run_job(input logic [1:0] m, input int cnt, input int stall_kind,
                          input bit rand_valid, input bit poke, input int abort_after);
      int sent, outs, k, last_k, target;
      bit acc, prev_acc, stall, in_v;
      exp_q.delete();
      sent = 0; outs = 0; k = 0; last_k = 0; prev_acc = 1'b0;
      target = (abort_after < cnt) ? abort_after : cnt;
      launch(m, cnt);
      chk("ro2_cleared", ro[2], 32'd0);
      while (outs < target && k < 2000) begin
         k++;
         case (stall_kind)
            1:       stall = (k >= 3 && k < 8);
            2:       stall = ($urandom_range(0, 3) == 0);
            default: stall = 1'b0;
         endcase
         in_v      = (sent < cnt) && (!rand_valid || $urandom_range(0, 2) != 0);
         acc_ready = !stall;
         in_valid  = in_v;
         in_data   = in_v ? beats[sent] : 512'd0;
         if (poke && k == 2) begin
            csr_set[0] = 32'd2;
            csr_set[1] = 32'd7;
            csr_valid  = 1'b1;
         end else begin
            csr_valid = 1'b0;
         end
         #1;
         chk("busy_run", ro[0], 32'd1);
         if (poke && k == 2) chk("csr_ready_run", csr_ready, 1'b0);
         chk("in_ready", in_ready, (sent < cnt) && (!out_valid || !stall));
         if (prev_acc) chk("latency_valid", out_valid, 1'b1);
         if (out_valid) begin
            chk("out_pending", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) chk("out_data", out_data, exp_q[0]);
         end else begin
            chk("no_lost_beat", exp_q.size(), 0);
         end
         if (out_valid && !stall && exp_q.size() > 0) begin
            last_out = out_data;
            void'(exp_q.pop_front());
            outs++;
            last_k = k;
         end
         acc = in_v && in_ready;
         if (acc) begin
            exp_q.push_back(model(m, beats[sent]));
            sent++;
         end
         prev_acc = acc;
         @(negedge clk);
      end
      csr_valid = 1'b0;
      chk("job_progress", outs, target);
      if (abort_after >= cnt) begin
         in_valid  = 1'b0;
         acc_ready = 1'b1;
         #1;
         chk("busy_end", ro[0], 32'd0);
         chk("valid_end", out_valid, 1'b0);
         chk("in_ready_end", in_ready, 1'b0);
         chk("csr_ready_end", csr_ready, 1'b1);
         chk("ro2_beats", ro[2], cnt);
         chk("ro1_cycles", ro[1], last_k);
         @(negedge clk);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      in_data   = 512'd0;
      in_valid  = 1'b0;
      acc_ready = 1'b1;
      csr_set   = 64'd0;
      csr_valid = 1'b0;
      last_out  = 512'd0;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_data", out_data, 512'd0);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_ro", ro, 96'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_csr_ready", csr_ready, 1'b1);
      @(negedge clk);

      // Mode 0, four replicated beats, no backpressure.
      for (int i = 0; i < 4; i++) beats[i] = {64{8'(i + 1)}};
      run_job(2'd0, 4, 0, 1'b0, 1'b0, 99);
      chk("pass_last", last_out, {64{8'h04}});
      chk("pass_ro1_is5", ro[1], 32'd5);

      // Mode 1 transpose of an index ramp.
      for (int e = 0; e < 64; e++) beats[0][e*8 +: 8] = 8'(e);
      run_job(2'd1, 1, 0, 1'b0, 1'b0, 99);
      chk("tr_byte1", last_out[15:8], 8'd8);
      chk("tr_byte63", last_out[511:504], 8'd63);
      chk("tr_byte8", last_out[71:64], 8'd1);

      // Mode 2 reverse of the same ramp.
      run_job(2'd2, 1, 0, 1'b0, 1'b0, 99);
      chk("rev_byte0", last_out[7:0], 8'd63);
      chk("rev_byte63", last_out[511:504], 8'd0);

      // Mode 0 with a five-cycle stall and an ignored CSR poke mid-run.
      fill_random(3);
      run_job(2'd0, 3, 1, 1'b0, 1'b1, 99);

      // Zero-count launch is a no-op.
      launch(2'd1, 0);
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("nop_busy", ro[0], 32'd0);
         chk("nop_csr_ready", csr_ready, 1'b1);
         chk("nop_valid", out_valid, 1'b0);
         chk("nop_in_ready", in_ready, 1'b0);
         @(negedge clk);
      end
      in_valid = 1'b0;

      // Random jobs with random valid gaps and backpressure.
      for (int j = 0; j < 6; j++) begin
         int cnt;
         cnt = $urandom_range(1, 8);
         fill_random(cnt);
         run_job(2'($urandom_range(0, 3)), cnt, 2, 1'b1, 1'b0, 99);
      end

      // Reset mid-job after two outputs, then a fresh job.
      fill_random(6);
      run_job(2'd0, 6, 0, 1'b0, 1'b0, 2);
      rst_n = 1'b0;
      #1;
      chk("abort_valid", out_valid, 1'b0);
      chk("abort_busy", ro[0], 32'd0);
      chk("abort_ro1", ro[1], 32'd0);
      chk("abort_ro2", ro[2], 32'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      in_valid  = 1'b1;
      in_data   = beats[0];
      acc_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("post_rst_valid", out_valid, 1'b0);
         chk("post_rst_in_ready", in_ready, 1'b0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      fill_random(2);
      run_job(2'd2, 2, 0, 1'b0, 1'b0, 99);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
